// File: rtl/sum_display_pkg.sv
// Shared constants for the sum/operand seven-segment scan display.
// Anode and segment codes are active-low throughout.
package sum_display_pkg;

    localparam int DEFAULT_REFRESH_DIV = 100_000;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_D0   = 4'b1110;
    localparam logic [3:0] AN_D1   = 4'b1101;
    localparam logic [3:0] AN_D2   = 4'b1011;
    localparam logic [3:0] AN_D3   = 4'b0111;
    localparam logic [3:0] AN_NONE = 4'b1111;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_SUM   = 2'd0;
    localparam digit_idx_t DIG_BLANK = 2'd1;
    localparam digit_idx_t DIG_B     = 2'd2;
    localparam digit_idx_t DIG_A     = 2'd3;

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational.
module seg7_decode
    import sum_display_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/sum_display_scan.sv
// Scans operand A, operand B and the adder sum across a 4-digit display.
// Carry-out lights the decimal point of the sum digit.
module sum_display_scan
    import sum_display_pkg::*;
#(
    parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [2:0] sum,
    input  logic       hold,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [1:0]    a_q;
    logic [1:0]    b_q;
    logic [2:0]    sum_q;
    logic [CW-1:0] cnt;
    digit_idx_t    idx;

    logic [3:0] nib;
    logic [3:0] an_d;
    logic       dp_d;
    logic       blank;
    logic [6:0] dec_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
        end else if (!hold) begin
            a_q   <= a;
            b_q   <= b;
            sum_q <= sum;
        end
    end

    // Digit index steps once per full refresh slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= DIG_SUM;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        nib   = '0;
        an_d  = AN_NONE;
        dp_d  = 1'b1;
        blank = 1'b1;
        unique case (idx)
            DIG_SUM: begin
                nib   = {1'b0, sum_q};
                an_d  = AN_D0;
                dp_d  = ~sum_q[2];
                blank = 1'b0;
            end
            DIG_BLANK: begin
                nib   = '0;
                an_d  = AN_NONE;
                blank = 1'b1;
            end
            DIG_B: begin
                nib   = {2'b00, b_q};
                an_d  = AN_D2;
                blank = 1'b0;
            end
            DIG_A: begin
                nib   = {2'b00, a_q};
                an_d  = AN_D3;
                blank = 1'b0;
            end
        endcase
    end

    seg7_decode u_dec (
        .value (nib),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_NONE;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= blank ? SEG_BLANK : dec_seg;
            dp  <= dp_d;
        end
    end

endmodule
